// File: rtl/fetch_unit.sv
// fetch_unit: program counter owner and single-outstanding instruction fetch stage driving r15 and decode
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        pc_wen,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);
  typedef enum logic [1:0] {INIT, REQ, OUT, DRAIN} state_t;
  state_t state, state_nx;
  logic [31:0] pc, req_addr, tgt, pc_inc, req_nx;
  logic req_ld, capture;
  assign tgt = br_target & 32'hFFFF_FFFC;
  assign pc_inc = pc + PC_STEP;
  assign imem_req = (state == REQ) || (state == DRAIN);
  assign imem_addr = req_addr;
  assign instr_valid = (state == OUT);
  always_comb begin
    state_nx = state;
    pc_wen = 1'b0;
    pc_next = pc;
    req_ld = 1'b0;
    req_nx = pc;
    capture = 1'b0;
    case (state)
      INIT: begin
        pc_wen = 1'b1;
        req_ld = 1'b1;
        state_nx = REQ;
      end
      REQ: begin
        pc_wen = br_taken;
        pc_next = tgt;
        req_ld = br_taken & imem_ready;
        req_nx = tgt;
        capture = imem_ready & ~br_taken;
        state_nx = br_taken ? (imem_ready ? REQ : DRAIN) : (imem_ready ? OUT : REQ);
      end
      DRAIN: begin
        pc_wen = br_taken;
        pc_next = tgt;
        req_ld = imem_ready;
        req_nx = br_taken ? tgt : pc;
        state_nx = imem_ready ? REQ : DRAIN;
      end
      OUT: begin
        pc_wen = br_taken | instr_ready;
        pc_next = br_taken ? tgt : pc_inc;
        req_ld = br_taken | instr_ready;
        req_nx = br_taken ? tgt : pc_inc;
        state_nx = (br_taken | instr_ready) ? REQ : OUT;
      end
      default: state_nx = INIT;
    endcase
    pc_wen = pc_wen & ~reset;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      pc <= RESET_PC;
      req_addr <= RESET_PC;
      instr <= 32'h0;
      instr_pc <= 32'h0;
    end else begin
      state <= state_nx;
      if (pc_wen) pc <= pc_next;
      if (req_ld) req_addr <= req_nx;
      if (capture) begin
        instr <= imem_rdata;
        instr_pc <= req_addr;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random and directed fetch traffic against a transaction-level model, two reset addresses
module tb_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, br_taken, imem_ready, instr_ready;
  logic [31:0] br_target, imem_rdata;
  logic wen [2];
  logic req [2];
  logic vld [2];
  logic [31:0] nxt [2];
  logic [31:0] addr [2];
  logic [31:0] ins [2];
  logic [31:0] ipc [2];
  int total = 0;
  int bad = 0;
  fetch_unit u_dut (
    .clk(clk), .reset(reset), .br_taken(br_taken), .br_target(br_target),
    .pc_wen(wen[0]), .pc_next(nxt[0]), .imem_req(req[0]), .imem_addr(addr[0]),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_valid(vld[0]),
    .instr(ins[0]), .instr_pc(ipc[0]), .instr_ready(instr_ready)
  );
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset), .br_taken(br_taken), .br_target(br_target),
    .pc_wen(wen[1]), .pc_next(nxt[1]), .imem_req(req[1]), .imem_addr(addr[1]),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_valid(vld[1]),
    .instr(ins[1]), .instr_pc(ipc[1]), .instr_ready(instr_ready)
  );
  logic [31:0] m_pc [2];
  logic [31:0] m_req [2];
  logic [31:0] m_ins [2];
  logic [31:0] m_ipc [2];
  bit m_ok [2];
  bit m_init [2];
  bit m_have [2];
  bit m_stale [2];
  function automatic logic [31:0] rst_pc(int k);
    return k == 0 ? 32'h0000_0000 : 32'hFFFF_FFFC;
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(bit r, bit b, logic [31:0] t, bit ir, bit idr);
    logic [31:0] tgt, ev, np;
    bit ew [2];
    logic [31:0] evs [2];
    @(negedge clk);
    reset = r;
    br_taken = b;
    br_target = t;
    imem_ready = ir;
    imem_rdata = $urandom;
    instr_ready = idr;
    tgt = {t[31:2], 2'b00};
    #1;
    for (int k = 0; k < 2; k++) begin
      ew[k] = !r && (m_init[k] || b || (m_have[k] && idr));
      ev = m_init[k] ? m_pc[k] : (b ? tgt : m_pc[k] + 32'd4);
      evs[k] = ev;
      if (m_ok[k]) begin
        check($sformatf("u%0d pc_wen", k), {31'b0, wen[k]}, {31'b0, ew[k]});
        if (ew[k]) check($sformatf("u%0d pc_next", k), nxt[k], ev);
        check($sformatf("u%0d imem_req", k), {31'b0, req[k]}, {31'b0, !m_init[k] && !m_have[k]});
        if (!m_init[k] && !m_have[k]) check($sformatf("u%0d imem_addr", k), addr[k], m_req[k]);
        check($sformatf("u%0d instr_valid", k), {31'b0, vld[k]}, {31'b0, m_have[k]});
        check($sformatf("u%0d instr", k), ins[k], m_ins[k]);
        check($sformatf("u%0d instr_pc", k), ipc[k], m_ipc[k]);
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_ok[k] = 1;
        m_init[k] = 1;
        m_have[k] = 0;
        m_stale[k] = 0;
        m_pc[k] = rst_pc(k);
        m_req[k] = rst_pc(k);
        m_ins[k] = 32'h0;
        m_ipc[k] = 32'h0;
      end else if (m_ok[k]) begin
        np = ew[k] ? evs[k] : m_pc[k];
        if (m_init[k]) begin
          m_init[k] = 0;
          m_req[k] = np;
        end else if (m_have[k]) begin
          if (b || idr) begin
            m_have[k] = 0;
            m_req[k] = np;
          end
        end else if (ir) begin
          if (m_stale[k] || b) begin
            m_stale[k] = 0;
            m_req[k] = np;
          end else begin
            m_have[k] = 1;
            m_ins[k] = imem_rdata;
            m_ipc[k] = m_req[k];
          end
        end else if (b) m_stale[k] = 1;
        m_pc[k] = np;
      end
    end
  endtask
  task automatic rst_init();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1);
    cyc(0, 1, 32'h0000_0555, 0, 0);
  endtask
  initial begin
    for (int k = 0; k < 2; k++) m_ok[k] = 0;
    rst_init();
    repeat (8) cyc(0, 0, 0, 1, 1);
    rst_init();
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    repeat (4) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1);
    rst_init();
    cyc(0, 1, 32'h0000_0103, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    rst_init();
    cyc(0, 1, 32'h0000_0200, 1, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    rst_init();
    cyc(0, 1, 32'h0000_0040, 0, 0);
    cyc(0, 1, 32'h0000_0081, 0, 0);
    cyc(1, 0, 0, 1, 1);
    cyc(1, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 149) == 0, $urandom_range(0, 7) == 0, $urandom,
          $urandom_range(0, 1) == 1, $urandom_range(0, 4) < 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the 16x32 register file.
- Owns the program counter and drives the register file's r15 write port (wEn15/wDr15), so r15 always holds the current fetch address.
- Issues word requests to instruction memory over a req/ready handshake and presents fetched instructions to decode over a valid/ready handshake.
- Branch redirects, including ALU writes to r15, arrive on br_taken/br_target.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded after reset. Bits [1:0] must be 0.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  synchronous, active-high
- br_taken  in  1  single-cycle redirect strobe
- br_target  in  32  redirect address; bits [1:0] are ignored
- pc_wen  out  1  to regfile wEn15
- pc_next  out  32  to regfile wDr15
- imem_req  out  1  memory request
- imem_addr  out  32  request address; held stable while imem_req=1
- imem_ready  in  1  response strobe; imem_rdata is valid in this cycle
- imem_rdata  in  32  instruction word
- instr_valid  out  1  decode output valid
- instr  out  32  held instruction
- instr_pc  out  32  address of instr
- instr_ready  in  1  decode accepts

Behaviour:
- Internal registers:
  - pc: the fetch address, mirrored into r15.
  - req_addr: the address of the outstanding request.
  - instr/instr_pc holding registers.
  - state: INIT, REQ, OUT, DRAIN.
- pc_wen and pc_next are combinational from state and inputs. The regfile captures them on the same edge that pc updates.
- All other outputs are registered or decoded from state.
- Reset (clk edge with reset=1):
  - state<=INIT; pc<=RESET_PC; req_addr<=RESET_PC.
  - instr<=0, instr_pc<=0.
  - Decoded from INIT, all outputs read 0: imem_req=0, instr_valid=0, pc_wen=0.
  - Reset wins over every other event in any state, including DRAIN. A pending memory response is abandoned; memory must tolerate this.
- INIT (exactly 1 cycle):
  - pc_wen=1, pc_next=pc (=RESET_PC). This initialises r15, which has no reset of its own.
  - br_taken is ignored.
  - Next state: REQ, with req_addr=pc.
- REQ:
  - imem_req=1, imem_addr=req_addr.
  - imem_ready=1 and no branch: instr<=imem_rdata, instr_pc<=req_addr; go to OUT.
  - br_taken=1: pc<=T (T={br_target[31:2],2'b00}); pc_wen=1, pc_next=T.
    - If imem_ready=1 in the same cycle: the response is discarded; req_addr<=T; stay in REQ.
    - Otherwise: go to DRAIN. The old request completes undisturbed.
- DRAIN:
  - imem_req=1 with the old req_addr. On imem_ready the data is discarded, req_addr<=pc, and the next state is REQ.
  - br_taken in DRAIN: pc<=T, pc_wen=1. Stay in DRAIN, or go to REQ with req_addr<=T if imem_ready is also 1.
- OUT:
  - instr_valid=1, imem_req=0.
  - instr_valid&instr_ready: the transfer occurs. pc<=pc+PC_STEP (mod 2^32); pc_wen=1, pc_next=pc+PC_STEP; req_addr<=pc+PC_STEP; go to REQ.
  - No instr_ready: hold all outputs stable, no pc write.
  - br_taken (with or without instr_ready): pc/pc_next=T, pc_wen=1, req_addr<=T, go to REQ. A same-cycle transfer still counts as a transfer; downstream flushes it.
- At most one pc write per cycle. A branch always overrides the sequential increment.
- Latency: minimum 2 cycles per instruction (REQ with imem_ready=1 in the same cycle, then OUT with instr_ready=1). The first imem_req is asserted in the 2nd cycle after reset deasserts.
- Wrap: pc=32'hFFFF_FFFC steps to 32'h0000_0000. No flag is raised.
- Throughput is not pipelined: there is at most one outstanding memory request.

Test Plan:
- Reset, imem_ready tied 1, instr_ready tied 1 -> pc_wen with pc_next=0 in cycle 1; imem_addr sequence 0x0,0x4,0x8; instr_valid every 2nd cycle with instr_pc 0x0,0x4,0x8; pc_next 0x4,0x8,0xC.
- imem_ready delayed 3 cycles; instr_ready low 4 cycles in OUT -> imem_addr stable during the wait; instr/instr_pc stable while stalled; no pc_wen until the transfer.
- br_taken with br_target=0x103 in the 1st cycle of REQ (imem_ready low for 2 more cycles) -> pc_next=0x100 with pc_wen same cycle; imem_addr holds the old address until ready; the old data is never presented; next request is at 0x100.
- br_taken coincident with imem_ready in REQ -> rdata dropped; no instr_valid that round; next imem_addr=target; no DRAIN cycle.
- RESET_PC=32'hFFFF_FFFC, one accepted fetch -> pc_next=0x0; next imem_addr=0x0.
- reset asserted mid-DRAIN -> all outputs 0 next cycle; INIT write of RESET_PC; the stale imem_ready response is ignored.
